// File: rtl/ecc_scrubber.sv
// ecc_scrubber: background SECDED scrubber sharing one bank port with a primary requester
package ecc_pkg;

    // Hamming check bits r satisfy 2^r >= data + r + 1; one extra overall-parity bit on top
    function automatic int get_cw_width(input int dw);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if ((1 << r) < dw + r + 1) r = r + 1;
        return dw + r + 1;
    endfunction

endpackage

module ecc_scrubber #(
    parameter  int DataWidth = 32,
    parameter  int BankSize  = 256,
    localparam int AddrW     = $clog2(BankSize),
    localparam int CwWidth   = ecc_pkg::get_cw_width(DataWidth)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               scrub_trigger_i,
    output logic               bit_corrected_o,
    output logic               uncorrectable_o,
    output logic [AddrW-1:0]   scrub_addr_o,
    input  logic               intc_req_i,
    input  logic               intc_we_i,
    input  logic [AddrW-1:0]   intc_add_i,
    input  logic [CwWidth-1:0] intc_wdata_i,
    output logic [CwWidth-1:0] intc_rdata_o,
    output logic               bank_req_o,
    output logic               bank_we_o,
    output logic [AddrW-1:0]   bank_add_o,
    output logic [CwWidth-1:0] bank_wdata_o,
    input  logic [CwWidth-1:0] bank_rdata_i
);

    localparam int ParW = CwWidth - 1 - DataWidth;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

    typedef struct packed {
        logic                 single;
        logic                 double_err;
        logic [DataWidth-1:0] data;
    } dec_t;

    // Codeword bit p-1 holds Hamming position p; check bits sit at powers of two,
    // the top bit is overall parity across the whole word.
    function automatic logic [CwWidth-1:0] ecc_encode(input logic [DataWidth-1:0] d);
        logic [CwWidth-1:0] c;
        int j;
        c = '0;
        j = 0;
        for (int p = 1; p < CwWidth; p++)
            if ((p & (p - 1)) != 0) begin
                c[p-1] = d[j];
                j++;
            end
        for (int k = 0; k < ParW; k++)
            for (int p = 1; p < CwWidth; p++)
                if (((p >> k) & 1) != 0) c[(1 << k) - 1] = c[(1 << k) - 1] ^ c[p-1];
        c[CwWidth-1] = ^c[CwWidth-2:0];
        return c;
    endfunction

    // Odd overall parity means one flipped bit (syndrome 0 = the parity bit itself);
    // even parity with a nonzero syndrome, or a syndrome off the end, is a double error.
    function automatic dec_t ecc_decode(input logic [CwWidth-1:0] cw);
        dec_t r;
        logic [CwWidth-1:0] c;
        int syn;
        int j;
        syn = 0;
        for (int p = 1; p < CwWidth; p++)
            if (cw[p-1]) syn = syn ^ p;
        c = cw;
        r.single = (^cw) && syn < CwWidth;
        r.double_err = syn != 0 && !r.single;
        if (r.single && syn != 0) c[syn-1] = ~c[syn-1];
        r.data = '0;
        j = 0;
        for (int p = 1; p < CwWidth; p++)
            if ((p & (p - 1)) != 0) begin
                r.data[j] = c[p-1];
                j++;
            end
        return r;
    endfunction

    state_e             state_q, state_d;
    logic [AddrW-1:0]   addr_q, addr_d;
    logic [CwWidth-1:0] cw_q, cw_d;
    logic [AddrW-1:0]   addr_inc;
    logic               collide;
    dec_t               dec;

    assign dec          = ecc_decode(bank_rdata_i);
    assign addr_inc     = addr_q == AddrW'(BankSize - 1) ? '0 : addr_q + 1'b1;
    assign collide      = intc_req_i && intc_we_i && intc_add_i == addr_q;
    assign scrub_addr_o = addr_q;
    assign intc_rdata_o = bank_rdata_i;

    // Next state, bank arbitration (primary always wins) and error pulses
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        cw_d            = cw_q;
        bank_req_o      = intc_req_i;
        bank_we_o       = intc_we_i;
        bank_add_o      = intc_add_i;
        bank_wdata_o    = intc_wdata_i;
        bit_corrected_o = 1'b0;
        uncorrectable_o = 1'b0;
        case (state_q)
            IDLE: if (scrub_trigger_i && !intc_req_i) begin
                state_d = READ;
                if (rst_ni) begin
                    bank_req_o = 1'b1;
                    bank_we_o  = 1'b0;
                    bank_add_o = addr_q;
                end
            end
            READ: begin
                bit_corrected_o = dec.single;
                uncorrectable_o = dec.double_err;
                cw_d            = dec.single ? ecc_encode(dec.data) : cw_q;
                state_d         = dec.single && !collide ? WRITE : IDLE;
                addr_d          = dec.single && !collide ? addr_q : addr_inc;
            end
            WRITE: if (!intc_req_i) begin
                bank_req_o   = 1'b1;
                bank_we_o    = 1'b1;
                bank_add_o   = addr_q;
                bank_wdata_o = cw_q;
                state_d      = IDLE;
                addr_d       = addr_inc;
            end else if (collide) begin
                state_d = IDLE;
                addr_d  = addr_inc;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, scrub pointer and pending write-back codeword
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cw_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cw_q    <= cw_d;
        end
    end

endmodule

// File: tb/tb_ecc_scrubber.sv
// tb_ecc_scrubber: randomized scrub walk against a word-level error model of the bank
module tb_ecc_scrubber;

    localparam int DW = 32;
    localparam int BS = 16;
    localparam int AW = 4;
    localparam int CW = 39;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          trig = 1'b0;
    logic          intc_req = 1'b0;
    logic          intc_we = 1'b0;
    logic [AW-1:0] intc_add = '0;
    logic [CW-1:0] intc_wdata = '0;
    logic          bit_corr, unc, bank_req, bank_we;
    logic [AW-1:0] saddr, bank_add;
    logic [CW-1:0] bank_wdata, intc_rdata;
    logic [CW-1:0] bank_rdata = '0;

    logic [CW-1:0] mem [BS];
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [CW-1:0] bd_data = '0;

    logic [31:0]   gold [BS];
    int            flips [BS];
    int            exp_addr = 0;

    int            n_chk = 0, n_err = 0;
    int            corr_cnt = 0, unc_cnt = 0, wr_cnt = 0, rd_cnt = 0;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [CW-1:0] wr_data = '0;

    always #5 clk = ~clk;

    ecc_scrubber #(.DataWidth(DW), .BankSize(BS)) dut (
        .clk_i(clk), .rst_ni(rst_n), .scrub_trigger_i(trig),
        .bit_corrected_o(bit_corr), .uncorrectable_o(unc), .scrub_addr_o(saddr),
        .intc_req_i(intc_req), .intc_we_i(intc_we), .intc_add_i(intc_add),
        .intc_wdata_i(intc_wdata), .intc_rdata_o(intc_rdata),
        .bank_req_o(bank_req), .bank_we_o(bank_we), .bank_add_o(bank_add),
        .bank_wdata_o(bank_wdata), .bank_rdata_i(bank_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Reference encoding: data fills non-power-of-two positions, check bit k is bit k
    // of the XOR of the positions holding ones, top bit makes total parity even.
    function automatic logic [CW-1:0] tb_encode(input logic [31:0] d);
        logic [CW-1:0] c = '0;
        int j = 0;
        int s = 0;
        for (int pos = 1; pos < CW; pos++)
            if ((pos & (pos - 1)) != 0) begin
                c[pos-1] = d[j];
                if (d[j]) s = s ^ pos;
                j++;
            end
        for (int k = 0; k < 6; k++) c[(1 << k) - 1] = s[k];
        c[CW-1] = ^c;
        return c;
    endfunction

    function automatic logic [CW-1:0] rmask(input int k);
        logic [CW-1:0] m = '0;
        int b1 = $urandom_range(0, CW - 1);
        if (k > 0) m[b1] = 1'b1;
        if (k == 2) m[(b1 + 1 + $urandom_range(0, CW - 2)) % CW] = 1'b1;
        return m;
    endfunction

    function automatic int nxt(input int a);
        return (a + 1) % BS;
    endfunction

    // Bank SRAM with one-cycle read latency plus a backdoor port for error injection
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (bank_req && bank_we) mem[bank_add] <= bank_wdata;
        if (bank_req && !bank_we) bank_rdata <= mem[bank_add];
    end

    // Bus monitor: pulses, scrub-owned accesses, and primary passthrough
    always @(negedge clk) begin
        if (bit_corr) corr_cnt++;
        if (unc) unc_cnt++;
        if (intc_req)
            chk("passthru", {bank_req, bank_we, bank_add, bank_wdata}, {1'b1, intc_we, intc_add, intc_wdata});
        else if (bank_req && bank_we) begin
            wr_cnt++;
            wr_addr = bank_add;
            wr_data = bank_wdata;
        end else if (bank_req) begin
            rd_cnt++;
            rd_addr = bank_add;
        end
    end

    task tick;
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input int a, input logic [CW-1:0] v);
        bd_we = 1'b1;
        bd_addr = AW'(a);
        bd_data = v;
        tick;
        bd_we = 1'b0;
    endtask

    task automatic inject(input int a, input int kind, input logic [CW-1:0] m);
        poke(a, tb_encode(gold[a]) ^ m);
        flips[a] = kind;
    endtask

    task automatic step(input int stall);
        int a, kind, c0, u0, w0, r0, lat, explat;
        bit done;
        a = exp_addr;
        kind = flips[a];
        c0 = corr_cnt; u0 = unc_cnt; w0 = wr_cnt; r0 = rd_cnt;
        trig = 1'b1;
        tick;
        trig = 1'b0;
        lat = 1;
        done = 1'b0;
        for (int i = 0; i < 40 && !(done && i >= stall); i++) begin
            intc_req = i < stall;
            intc_we = 1'b0;
            intc_add = AW'($urandom);
            tick;
            if (!done) begin
                lat++;
                done = saddr != AW'(a);
            end
        end
        intc_req = 1'b0;
        explat = kind == 1 ? (stall > 1 ? stall + 2 : 3) : 2;
        chk("step_done", done, 1);
        chk("rd_cnt", rd_cnt - r0, 1);
        chk("rd_addr", rd_addr, a);
        chk("latency", lat, explat);
        chk("corr_pulse", corr_cnt - c0, kind == 1);
        chk("unc_pulse", unc_cnt - u0, kind == 2);
        chk("wb_cnt", wr_cnt - w0, kind == 1);
        if (kind == 1) begin
            chk("wb_addr", wr_addr, a);
            chk("wb_data", wr_data, tb_encode(gold[a]));
            flips[a] = 0;
        end
        chk("scrub_addr", saddr, nxt(a));
        exp_addr = nxt(a);
    endtask

    task automatic collide;
        int a, c0, w0;
        logic [31:0] nd;
        logic [CW-1:0] x;
        a = exp_addr;
        nd = $urandom;
        x = tb_encode(nd);
        c0 = corr_cnt; w0 = wr_cnt;
        trig = 1'b1;
        tick;
        trig = 1'b0;
        tick;
        intc_req = 1'b1; intc_we = 1'b1; intc_add = AW'(a); intc_wdata = x;
        tick;
        intc_req = 1'b0; intc_we = 1'b0;
        chk("coll_addr", saddr, nxt(a));
        chk("coll_corr", corr_cnt - c0, 1);
        chk("coll_nowb", wr_cnt - w0, 0);
        intc_req = 1'b1; intc_add = AW'(a);
        tick;
        intc_req = 1'b0;
        chk("coll_hold", intc_rdata, x);
        gold[a] = nd;
        flips[a] = 0;
        exp_addr = nxt(a);
    endtask

    task automatic reset_in_write;
        int w0;
        inject(exp_addr, 1, rmask(1));
        w0 = wr_cnt;
        trig = 1'b1;
        tick;
        trig = 1'b0;
        tick;
        rst_n = 1'b0;
        trig = 1'b1;
        @(negedge clk);
        chk("rst_req", bank_req, 0);
        chk("rst_addr", saddr, 0);
        chk("rst_corr", bit_corr, 0);
        chk("rst_unc", unc, 0);
        intc_req = 1'b1; intc_add = 4'd5;
        #1;
        chk("rst_pass", {bank_req, bank_add}, {1'b1, 4'd5});
        tick;
        trig = 1'b0;
        intc_req = 1'b0;
        tick;
        chk("rst_nowb", wr_cnt - w0, 0);
        rst_n = 1'b1;
        tick;
        exp_addr = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        for (int a = 0; a < BS; a++) begin
            gold[a] = $urandom;
            flips[a] = 0;
        end
        gold[0] = 32'hDEADBEEF;
        trig = 1'b1;
        repeat (2) tick;
        @(negedge clk);
        chk("init_addr", saddr, 0);
        chk("init_corr", bit_corr, 0);
        chk("init_unc", unc, 0);
        chk("init_req", bank_req, 0);
        trig = 1'b0;
        for (int a = 0; a < BS; a++) poke(a, tb_encode(gold[a]));
        for (int a = 1; a < BS; a++)
            if (a != 3 && a != 7 && a != 10 && a != 12) begin
                int k = $urandom_range(0, 2);
                if (k != 0) inject(a, k, rmask(k));
            end
        inject(3, 1, CW'(1) << 5);
        inject(7, 2, (CW'(1) << 2) | (CW'(1) << 9));
        inject(10, 1, rmask(1));
        inject(12, 1, rmask(1));
        rst_n = 1'b1;
        tick;
        for (int a = 0; a < 12; a++)
            step(a == 10 ? 4 : (a == 0 || a == 3 || a == 7) ? 0 : $urandom_range(0, 2));
        collide();
        repeat (5) step($urandom_range(0, 3));
        reset_in_write();
        repeat (24) begin
            if ($urandom_range(0, 2) == 0) begin
                int k = $urandom_range(0, 2);
                inject(exp_addr, k, rmask(k));
            end
            step($urandom_range(0, 4));
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
